// File: rtl/decoder_3to8_strobe.sv
// Registered 3-to-8 decoder with a valid/ready handshake and a timed
// one-hot strobe. Each accepted code drives its line for HOLD_CYCLES
// cycles, followed by GAP_CYCLES all-zero cycles before the next accept.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a code; in_ready=1, out=0
// S_DRIVE | one-hot strobe on out; out_valid=1, busy=1, done on last cycle
// S_GAP   | forced all-zero spacing after a strobe; busy=1
module decoder_3to8_strobe #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       done,
    output logic       busy
);

    // Out-of-range timing parameters stop elaboration.
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("decoder_3to8_strobe: HOLD_CYCLES must be in 1..255");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("decoder_3to8_strobe: GAP_CYCLES must be in 0..255");
    end

    // Counter reload values; the gap value is unused when GAP_CYCLES is 0.
    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;

    // Single-process FSM: every output is a register updated alongside the
    // state, so nothing on the input side reaches the outputs combinationally.
    // The out register doubles as the latched code for the whole strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state     <= S_DRIVE;
                        cnt       <= HOLD_LD;
                        out       <= 8'b1 << in_code;
                        out_valid <= 1'b1;
                        done      <= (HOLD_CYCLES == 1);
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (cnt == 8'd0) begin
                        out       <= 8'h00;
                        out_valid <= 1'b0;
                        done      <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state    <= S_GAP;
                            cnt      <= GAP_LD;
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= S_IDLE;
                            cnt      <= 8'd0;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt - 8'd1;
                        // done must line up with the cycle the counter reads 0
                        done <= (cnt == 8'd1);
                    end
                end
                S_GAP: begin
                    if (cnt == 8'd0) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= 8'd0;
                    out       <= 8'h00;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Bench for decoder_3to8_strobe: two instances (default timing and
// HOLD=1/GAP=0) share one stimulus stream. A cycles-since-accept model
// predicts every output; directed steps also pin literal values.
module tb_decoder_3to8_strobe;

    localparam int HA = 4;
    localparam int GA = 1;
    localparam int HB = 1;
    localparam int GB = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_code = 3'd0;
    logic       in_valid = 1'b0;

    logic       a_ready, a_ov, a_done, a_busy;
    logic [7:0] a_out;
    logic       b_ready, b_ov, b_done, b_busy;
    logic [7:0] b_out;

    always #5 clk = ~clk;

    decoder_3to8_strobe #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(a_ready), .out(a_out), .out_valid(a_ov), .done(a_done), .busy(a_busy)
    );

    decoder_3to8_strobe #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(b_ready), .out(b_out), .out_valid(b_ov), .done(b_done), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: k = cycles elapsed since the accept edge (0 means idle).
    int         mk[2];
    logic [2:0] mcode[2];
    int         mh[2];
    int         mg[2];
    bit         armed = 1'b0;

    initial begin
        mk[0] = 0; mk[1] = 0;
        mcode[0] = 3'd0; mcode[1] = 3'd0;
        mh[0] = HA; mh[1] = HB;
        mg[0] = GA; mg[1] = GB;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) armed = 1'b1;
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                mk[j] = 0;
            end else if (mk[j] == 0) begin
                if (in_valid) begin
                    mk[j]    = 1;
                    mcode[j] = in_code;
                end
            end else begin
                mk[j] = mk[j] + 1;
                if (mk[j] > mh[j] + mg[j]) mk[j] = 0;
            end
        end
    end

    task automatic cmp_inst(int j, logic [7:0] o, logic ov, logic d, logic b, logic r);
        bit drive;
        bit gap;
        logic [7:0] eo;
        drive = (mk[j] >= 1) && (mk[j] <= mh[j]);
        gap   = (mk[j] > mh[j]);
        eo    = drive ? (8'h01 << mcode[j]) : 8'h00;
        chk($sformatf("out[%0d]", j), 32'(o), 32'(eo));
        chk($sformatf("out_valid[%0d]", j), 32'(ov), 32'(drive));
        chk($sformatf("done[%0d]", j), 32'(d), 32'(drive && mk[j] == mh[j]));
        chk($sformatf("busy[%0d]", j), 32'(b), 32'(drive || gap));
        chk($sformatf("in_ready[%0d]", j), 32'(r), 32'(mk[j] == 0));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp_inst(0, a_out, a_ov, a_done, a_busy, a_ready);
            cmp_inst(1, b_out, b_ov, b_done, b_busy, b_ready);
        end
    end

    task automatic wait_accept(int j, output int cycles);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (mk[j] != 1 && c < 40);
        if (mk[j] != 1) chk("accept_timeout", 32'd0, 32'd1);
        cycles = c;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c;
        logic [7:0] one;
        repeat (3) @(negedge clk);

        // single accept of code 5 on the default instance
        rst = 1'b0; in_code = 3'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_out_first", 32'(a_out), 32'h20);
        chk("t1_done_first", 32'(a_done), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_out_last", 32'(a_out), 32'h20);
        chk("t1_done_last", 32'(a_done), 32'd1);
        @(negedge clk);
        chk("t1_gap_out", 32'(a_out), 32'h00);
        chk("t1_gap_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        chk("t1_ready", 32'(a_ready), 32'd1);

        // sweep all codes with valid held high
        rst_pulse();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            wait_accept(0, c);
            one = 8'h01 << i;
            chk("t2_out", 32'(a_out), 32'(one));
            if (i > 0) chk("t2_spacing", 32'(c), 32'd6);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // input changes while busy are ignored
        in_code = 3'd2; in_valid = 1'b1;
        wait_accept(0, c);
        in_code = 3'd7;
        for (int n = 0; n < 4; n++) begin
            chk("t3_hold", 32'(a_out), 32'h04);
            @(negedge clk);
        end
        wait_accept(0, c);
        chk("t3_next", 32'(a_out), 32'h80);
        in_valid = 1'b0;

        // HOLD=1 / GAP=0 instance with continuous valid
        rst_pulse();
        in_code = 3'd1; in_valid = 1'b1;
        wait_accept(1, c);
        chk("t4_first", 32'(b_out), 32'h02);
        in_code = 3'd6;
        @(negedge clk);
        chk("t4_idle_out", 32'(b_out), 32'h00);
        chk("t4_idle_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        chk("t4_second", 32'(b_out), 32'h40);
        in_valid = 1'b0;

        // reset mid-strobe
        rst_pulse();
        in_code = 3'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_out", 32'(a_out), 32'h00);
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_done", 32'(a_done), 32'd0);
        chk("t5_ready", 32'(a_ready), 32'd1);
        rst = 1'b0; in_code = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5_restart", 32'(a_out), 32'h01);
        repeat (3) @(negedge clk);
        chk("t5_full_hold", 32'(a_out), 32'h01);
        chk("t5_full_done", 32'(a_done), 32'd1);

        // reset held with valid high
        rst = 1'b1; in_valid = 1'b1; in_code = 3'd4;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t6_rst_out", 32'(a_out), 32'h00);
        end
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_first_accept", 32'(a_out), 32'h10);

        // randomized traffic checked by the model every cycle
        repeat (400) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 49) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_code  = 3'($urandom_range(0, 7));
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
